decoder_seq: RTL and testbench

DECODER_SEQ -- requirements
Module: decoder_seq

---
 rtl/decoder_seq.sv | 125 ++++++++++++
 tb/tb_decoder_seq.sv | 137 +++++++++++++
 2 files changed

// File: rtl/decoder_seq.sv
// One-hot decoder with a direct-load path and an auto-scan sequencer; y/idx/y_valid are registered (1-cycle latency).
// Backpressure: in_ready = en & ~mode. Defining DECODER_SEQ_ACTIVE_LOW_EN inverts the y port.
module decoder_seq #(
    parameter int SEL_W    = 3,
    parameter int SCAN_DIV = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  mode,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [SEL_W-1:0]      sel,
    output logic [(2**SEL_W)-1:0] y,
    output logic                  y_valid,
    output logic [SEL_W-1:0]      idx,
    output logic                  scan_wrap
);
    localparam int OUT_W = 2**SEL_W;
    localparam int PW    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    typedef enum logic [1:0] {IDLE, DIRECT, SCAN} state_t;

    state_t            state, state_nx;
    logic [OUT_W-1:0]  y_q, y_nx;
    logic [SEL_W-1:0]  idx_q, idx_nx;
    logic              vld_q, vld_nx;
    logic              wrap_q, wrap_nx;
    logic [PW-1:0]     presc_q, presc_nx;
    logic              presc_last;

    assign in_ready   = en & ~mode;
    assign presc_last = (presc_q == PW'(SCAN_DIV - 1));

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        if (en) begin
            case (state)
                IDLE, DIRECT: begin
                    if (mode)          state_nx = SCAN;
                    else if (in_valid) state_nx = DIRECT;
                end
                SCAN:    if (!mode) state_nx = IDLE;
                default: state_nx = IDLE;
            endcase
        end
    end

    // Mode has priority over in_valid, so a sel presented while mode=1 is dropped.
    always_comb begin
        y_nx     = y_q;
        idx_nx   = idx_q;
        vld_nx   = vld_q;
        presc_nx = presc_q;
        wrap_nx  = 1'b0;
        if (en) begin
            case (state)
                IDLE, DIRECT: begin
                    if (mode) begin
                        y_nx     = OUT_W'(1);
                        idx_nx   = '0;
                        vld_nx   = 1'b1;
                        presc_nx = '0;
                    end else if (in_valid) begin
                        y_nx   = OUT_W'(1) << sel;
                        idx_nx = sel;
                        vld_nx = 1'b1;
                    end
                end
                SCAN: begin
                    if (!mode) begin
                        y_nx     = '0;
                        idx_nx   = '0;
                        vld_nx   = 1'b0;
                        presc_nx = '0;
                    end else if (presc_last) begin
                        presc_nx = '0;
                        idx_nx   = idx_q + SEL_W'(1);
                        y_nx     = OUT_W'(1) << (idx_q + SEL_W'(1));
                        wrap_nx  = &idx_q;
                    end else begin
                        presc_nx = presc_q + PW'(1);
                    end
                end
                default: begin
                    y_nx     = '0;
                    idx_nx   = '0;
                    vld_nx   = 1'b0;
                    presc_nx = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            y_q     <= '0;
            idx_q   <= '0;
            vld_q   <= 1'b0;
            wrap_q  <= 1'b0;
            presc_q <= '0;
        end else begin
            y_q     <= y_nx;
            idx_q   <= idx_nx;
            vld_q   <= vld_nx;
            wrap_q  <= wrap_nx;
            presc_q <= presc_nx;
        end
    end

`ifdef DECODER_SEQ_ACTIVE_LOW_EN
    assign y = ~y_q;
`else
    assign y = y_q;
`endif
    assign idx       = idx_q;
    assign y_valid   = vld_q;
    assign scan_wrap = wrap_q;

endmodule

// File: tb/tb_decoder_seq.sv
// Scoreboard bench for decoder_seq (SEL_W=3, SCAN_DIV=4); expected outputs are queued as stimulus is driven.
module tb_decoder_seq;
    logic       clk = 1'b0;
    logic       rst, en, mode, in_valid, in_ready, y_valid, scan_wrap;
    logic [2:0] sel, idx;
    logic [7:0] y;

    typedef struct {
        logic [7:0] y;
        logic [2:0] idx;
        logic       vld;
        logic       wrap;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    decoder_seq #(.SEL_W(3), .SCAN_DIV(4)) dut (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .in_valid(in_valid),
        .in_ready(in_ready), .sel(sel), .y(y), .y_valid(y_valid),
        .idx(idx), .scan_wrap(scan_wrap)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    function automatic logic [7:0] ypin(input logic [7:0] v);
`ifdef DECODER_SEQ_ACTIVE_LOW_EN
        return ~v;
`else
        return v;
`endif
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Queue the expectation for the coming edge, clock it, then pop and compare.
    task automatic step(input string tag, input logic [7:0] ey, input logic [2:0] ei,
                        input logic ev, input logic ew);
        exp_t e;
        sb.push_back('{ypin(ey), ei, ev, ew});
        @(posedge clk);
        #1;
        e = sb.pop_front();
        check({tag, ".y"},    32'(y),         32'(e.y));
        check({tag, ".idx"},  32'(idx),       32'(e.idx));
        check({tag, ".vld"},  32'(y_valid),   32'(e.vld));
        check({tag, ".wrap"}, 32'(scan_wrap), 32'(e.wrap));
    endtask

    initial begin
        logic [7:0] one;
        int         c;
        one = 8'h01;
        rst = 1'b1; en = 1'b1; mode = 1'b1; in_valid = 1'b1; sel = 3'd4;
        #1;
        step("reset0", 8'h00, 3'd0, 1'b0, 1'b0);
        step("reset1", 8'h00, 3'd0, 1'b0, 1'b0);

        rst = 1'b0; mode = 1'b0; in_valid = 1'b0;
        #1 check("rdy_direct", 32'(in_ready), 32'd1);
        mode = 1'b1;
        #1 check("rdy_mode1", 32'(in_ready), 32'd0);
        mode = 1'b0; en = 1'b0;
        #1 check("rdy_en0", 32'(in_ready), 32'd0);
        en = 1'b1;

        // Direct sweep: one accept per cycle.
        in_valid = 1'b1;
        for (int s = 0; s < 8; s++) begin
            sel = 3'(s);
            step("sweep", one << s, 3'(s), 1'b1, 1'b0);
        end

        // Accept 5, then idle with in_valid low.
        sel = 3'd5;
        step("acc5", 8'h20, 3'd5, 1'b1, 1'b0);
        in_valid = 1'b0; sel = 3'd1;
        for (int k = 0; k < 10; k++) step("hold5", 8'h20, 3'd5, 1'b1, 1'b0);

        // en=0 in DIRECT blocks an accept.
        en = 1'b0; in_valid = 1'b1; sel = 3'd2;
        step("dir_en0", 8'h20, 3'd5, 1'b1, 1'b0);
        en = 1'b1; in_valid = 1'b1;

        // Auto-scan with in_valid held high: mode wins.
        mode = 1'b1; sel = 3'd7;
        for (c = 0; c <= 45; c++)
            step("scan", one << ((c / 4) % 8), 3'((c / 4) % 8), 1'b1, (c == 32));

        // Pause at idx=3 with prescaler at 1, then resume with remaining count.
        en = 1'b0;
        #1 check("rdy_pause", 32'(in_ready), 32'd0);
        for (int k = 0; k < 7; k++) step("pause", 8'h08, 3'd3, 1'b1, 1'b0);
        en = 1'b1;
        for (c = 46; c <= 66; c++)
            step("resume", one << ((c / 4) % 8), 3'((c / 4) % 8), 1'b1, (c == 64));

        // Reset mid-scan with a pending sel=6.
        rst = 1'b1; in_valid = 1'b1; sel = 3'd6;
        step("rst_mid", 8'h00, 3'd0, 1'b0, 1'b0);
        rst = 1'b0; mode = 1'b0; in_valid = 1'b0;
        step("idle_after", 8'h00, 3'd0, 1'b0, 1'b0);

        in_valid = 1'b1; sel = 3'd6;
        step("acc6", 8'h40, 3'd6, 1'b1, 1'b0);
        in_valid = 1'b0;

        // DIRECT -> SCAN entry, then SCAN -> IDLE clears outputs.
        mode = 1'b1;
        step("scan_entry", 8'h01, 3'd0, 1'b1, 1'b0);
        mode = 1'b0;
        step("scan_exit", 8'h00, 3'd0, 1'b0, 1'b0);

        // Accept after returning to IDLE.
        rst = 1'b1;
        step("reset2", 8'h00, 3'd0, 1'b0, 1'b0);
        rst = 1'b0; in_valid = 1'b1; sel = 3'd2;
        step("acc2", 8'h04, 3'd2, 1'b1, 1'b0);
        in_valid = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
